// File: rtl/cla_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cla_arb_pkg
// Shared types and constants for the round-robin adder arbiter.
//   DATA_W      : operand width, fixed to the width of the shared adder
//   MAX_ID_W    : widest requester index supported (up to 8 requesters)
//   arb_state_e : arbitration state (IDLE / LOCKED to one owner)
//   resp_t      : contents of the registered response channel
// Optional build macro: CLA_ARB_FLAGS_EN adds zero/overflow flags to resp_t.
// ---------------------------------------------------------------------------
package cla_arb_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_ID_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic                last;
`ifdef CLA_ARB_FLAGS_EN
        logic                zero;
        logic                ovf;
`endif
    } resp_t;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cla_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// cla_rr_arbiter_if
// Bundles the requester-side and response-side handshakes of the arbiter.
// Signal names carry the arbiter's point of view (_i into it, _o out of it).
//   req_valid_i/req_ready_o : per-requester handshake (NUM_REQ bits)
//   req_a_i/req_b_i         : packed operands, requester k at [16k+15:16k]
//   req_cin_i/req_last_i    : per-requester carry-in and last-word flag
//   resp_*                  : single registered response channel
// Modports: slave = arbiter side, master = requesters/downstream side.
// Optional build macro: CLA_ARB_FLAGS_EN adds resp_zero_o and resp_ovf_o.
// ---------------------------------------------------------------------------
interface cla_rr_arbiter_if
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*DATA_W-1:0] req_a_i;
    logic [NUM_REQ*DATA_W-1:0] req_b_i;
    logic [NUM_REQ-1:0]        req_cin_i;
    logic [NUM_REQ-1:0]        req_last_i;

    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic [ID_W-1:0]           resp_id_o;
    logic [DATA_W-1:0]         resp_sum_o;
    logic                      resp_cout_o;
    logic                      resp_last_o;
`ifdef CLA_ARB_FLAGS_EN
    logic                      resp_zero_o;
    logic                      resp_ovf_o;
`endif

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_cin_i, req_last_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_id_o, resp_sum_o, resp_cout_o,
`ifdef CLA_ARB_FLAGS_EN
        output resp_zero_o, resp_ovf_o,
`endif
        output resp_last_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_cin_i, req_last_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_id_o, resp_sum_o, resp_cout_o,
`ifdef CLA_ARB_FLAGS_EN
        input  resp_zero_o, resp_ovf_o,
`endif
        input  resp_last_o
    );

endinterface

// File: rtl/carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder
// 16-bit adder built from 4-bit lookahead groups; group carries are formed
// from each group's generate/propagate pair.
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sum_o    : a_i + b_i + cin_i (mod 2^16)
//   cout_o   : carry out of bit 15
// ---------------------------------------------------------------------------
module carry_lookahead_adder
    import cla_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              cout_o
);
    localparam int NG = DATA_W / 4;

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] c;
    logic [NG-1:0]     grp_g;
    logic [NG-1:0]     grp_p;
    logic [NG:0]       grp_c;

    assign p        = a_i ^ b_i;
    assign g        = a_i & b_i;
    assign grp_c[0] = cin_i;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = 4 * gi;

            assign grp_p[gi] = &p[B +: 4];
            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);

            assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);

            // In-group carries expanded from the group carry-in.
            assign c[B]   = grp_c[gi];
            assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
        end
    endgenerate

    assign sum_o  = p ^ c;
    assign cout_o = grp_c[NG];

endmodule

// File: rtl/cla_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: finds the first set bit of valid_i at or
// after ptr_i, wrapping modulo NUM_REQ.
//   valid_i : candidate requests
//   ptr_i   : search start index
//   grant_o : one-hot winner (zero when nothing is valid)
//   idx_o   : index of the winner (zero when nothing is valid)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);
    always_comb begin
        logic found;
        int   cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cla_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cla_rr_arbiter
// Shares one 16-bit carry-lookahead adder between NUM_REQ requesters with
// round-robin arbitration. A word with req_last=0 locks the grant to its
// requester and the carry-out is fed into that requester's next word.
// Results leave through a single registered response channel (latency 1).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous abort of lock and pending response
//   bus (slave)   : request handshakes, operands and response channel
// Optional build macro: CLA_ARB_FLAGS_EN adds resp_zero_o / resp_ovf_o.
// ---------------------------------------------------------------------------
module cla_rr_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    cla_rr_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester operand views of the packed buses.
    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a_i[DATA_W*gi +: DATA_W];
            assign b_arr[gi] = bus.req_b_i[DATA_W*gi +: DATA_W];
        end
    endgenerate

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              carry_q, carry_d;
    logic              resp_valid_q, resp_valid_d;
    resp_t             resp_q, resp_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] ready;
    logic               can_accept;
    logic               accept;
    logic [ID_W-1:0]    acc_idx;
    logic [DATA_W-1:0]  op_a, op_b, add_sum;
    logic               op_cin, op_last, add_cout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Ready is held low while in reset so nothing looks accepted before the
    // flops come out of reset.
    always_comb begin
        can_accept = !resp_valid_q || bus.resp_ready_i;
        ready      = '0;
        if (rst_ni && can_accept && !clear_i) begin
            if (state_q == IDLE) begin
                ready = pick_grant;
            end else begin
                ready = NUM_REQ'(1) << owner_q;
            end
        end
    end

    assign accept  = |(bus.req_valid_i & ready);
    assign acc_idx = (state_q == IDLE) ? pick_idx : owner_q;
    assign op_a    = a_arr[acc_idx];
    assign op_b    = b_arr[acc_idx];
    // Continuation words take the carry left by the previous word.
    assign op_cin  = (state_q == IDLE) ? bus.req_cin_i[acc_idx] : carry_q;
    assign op_last = bus.req_last_i[acc_idx];

    carry_lookahead_adder u_adder (
        .a_i    (op_a),
        .b_i    (op_b),
        .cin_i  (op_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        carry_d      = carry_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;

        if (clear_i) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            carry_d      = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_d.id    = MAX_ID_W'(acc_idx);
            resp_d.sum   = add_sum;
            resp_d.cout  = add_cout;
            resp_d.last  = op_last;
`ifdef CLA_ARB_FLAGS_EN
            resp_d.zero  = (add_sum == '0);
            resp_d.ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                           (add_sum[DATA_W-1] != op_a[DATA_W-1]);
`endif
            carry_d      = add_cout;
            if (op_last) begin
                state_d = IDLE;
                // Fairness pointer moves only when a whole operation ends.
                ptr_d   = ID_W'(wrap_inc(int'(acc_idx), NUM_REQ));
            end else begin
                state_d = LOCKED;
                owner_d = acc_idx;
            end
        end else if (resp_valid_q && bus.resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= '0;
            carry_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            carry_q      <= carry_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    generate
        if (ID_W < MAX_ID_W) begin : g_id_sink
            logic unused_id_bits;
            assign unused_id_bits = ^resp_q.id[MAX_ID_W-1:ID_W];
        end
    endgenerate

    assign bus.req_ready_o  = ready;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_id_o    = resp_q.id[ID_W-1:0];
    assign bus.resp_sum_o   = resp_q.sum;
    assign bus.resp_cout_o  = resp_q.cout;
    assign bus.resp_last_o  = resp_q.last;
`ifdef CLA_ARB_FLAGS_EN
    assign bus.resp_zero_o  = resp_q.zero;
    assign bus.resp_ovf_o   = resp_q.ovf;
`endif

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cla_rr_arbiter
// Directed vector table, reset/abort sequences and a randomized run checked
// against a cycle-level reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_cla_rr_arbiter;
    localparam int N = 4;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;

    cla_rr_arbiter_if #(.NUM_REQ(N)) bus ();

    cla_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [63:0] av, input logic [63:0] bv,
                         input logic [3:0] cin, input logic [3:0] last,
                         input logic rr, input logic clr);
        bus.req_valid_i  = v;
        bus.req_a_i      = av;
        bus.req_b_i      = bv;
        bus.req_cin_i    = cin;
        bus.req_last_i   = last;
        bus.resp_ready_i = rr;
        clear_i          = clr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cin;
        logic [3:0]  last;
        logic        rr;
        logic        clr;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_last;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] cin, input logic [3:0] last, input logic rr,
                                input logic clr, input logic [3:0] er, input logic rv,
                                input logic [1:0] id, input logic [15:0] s, input logic co,
                                input logic l);
        vec_t t;
        t.valid = v;  t.a = a; t.b = b; t.cin = cin; t.last = last; t.rr = rr; t.clr = clr;
        t.exp_ready = er; t.exp_rv = rv; t.exp_id = id; t.exp_sum = s; t.exp_cout = co;
        t.exp_last = l;
        return t;
    endfunction

    // ---------------- reference model ----------------
    logic        m_locked;
    int          m_owner, m_ptr;
    logic        m_carry;
    logic        m_rv;
    int          m_id;
    logic [15:0] m_sum;
    logic        m_cout, m_last;

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_carry = 1'b0;
        m_rv = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_last = 1'b0;
    endtask

    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic rr, input logic clr);
        logic [3:0] er;
        er = '0;
        if (!clr && (!m_rv || rr)) begin
            if (m_locked) begin
                er[m_owner] = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (er == '0 && v[(m_ptr + i) % N]) er[(m_ptr + i) % N] = 1'b1;
                end
            end
        end
        return er;
    endfunction

    task automatic model_update(input logic [3:0] v, input logic [63:0] av, input logic [63:0] bv,
                                input logic [3:0] cin, input logic [3:0] last,
                                input logic rr, input logic clr, input logic [3:0] er);
        int k;
        int s;
        if (clr) begin
            m_locked = 1'b0; m_rv = 1'b0; m_carry = 1'b0;
        end else if ((v & er) != '0) begin
            k = 0;
            for (int i = 0; i < N; i++) if (er[i]) k = i;
            s = int'(av[16*k +: 16]) + int'(bv[16*k +: 16]) + int'(m_locked ? m_carry : cin[k]);
            m_sum  = s[15:0];
            m_cout = s[16];
            m_id   = k;
            m_last = last[k];
            m_rv   = 1'b1;
            m_carry = m_cout;
            if (last[k]) begin
                m_locked = 1'b0;
                m_ptr    = (k + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = k;
            end
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
    endtask

    initial begin
        logic [3:0]  rv4, rc4, rl4, er;
        logic [63:0] ra, rb;
        logic        rrr, rcl;

        vecs[0]  = mk(4'b0001, 16'h1234, 16'h4321, 4'hF, 4'hF, 1, 0, 4'b0001, 1, 0, 16'h5556, 0, 1);
        vecs[1]  = mk(4'b1111, 16'h0001, 16'h0002, 4'h0, 4'hF, 1, 0, 4'b0010, 1, 1, 16'h0003, 0, 1);
        vecs[2]  = mk(4'b1111, 16'h0001, 16'h0002, 4'h0, 4'hF, 1, 0, 4'b0100, 1, 2, 16'h0003, 0, 1);
        vecs[3]  = mk(4'b1111, 16'h0001, 16'h0002, 4'h0, 4'hF, 1, 0, 4'b1000, 1, 3, 16'h0003, 0, 1);
        vecs[4]  = mk(4'b1111, 16'h0001, 16'h0002, 4'h0, 4'hF, 1, 0, 4'b0001, 1, 0, 16'h0003, 0, 1);
        vecs[5]  = mk(4'b1111, 16'h0001, 16'h0002, 4'h0, 4'hF, 1, 0, 4'b0010, 1, 1, 16'h0003, 0, 1);
        // chain on req2 with req1 waiting
        vecs[6]  = mk(4'b0110, 16'hFFFF, 16'h0001, 4'h0, 4'b1011, 1, 0, 4'b0100, 1, 2, 16'h0000, 1, 0);
        vecs[7]  = mk(4'b0110, 16'h0000, 16'h0000, 4'h0, 4'hF, 1, 0, 4'b0100, 1, 2, 16'h0001, 0, 1);
        vecs[8]  = mk(4'b0011, 16'h0005, 16'h0007, 4'h0, 4'hF, 1, 0, 4'b0001, 1, 0, 16'h000C, 0, 1);
        vecs[9]  = mk(4'b0010, 16'h0005, 16'h0007, 4'h0, 4'hF, 1, 0, 4'b0010, 1, 1, 16'h000C, 0, 1);
        // backpressure for three cycles
        vecs[10] = mk(4'b0100, 16'h1000, 16'h2000, 4'hF, 4'hF, 0, 0, 4'b0000, 1, 1, 16'h000C, 0, 1);
        vecs[11] = mk(4'b0100, 16'h1000, 16'h2000, 4'hF, 4'hF, 0, 0, 4'b0000, 1, 1, 16'h000C, 0, 1);
        vecs[12] = mk(4'b0100, 16'h1000, 16'h2000, 4'hF, 4'hF, 0, 0, 4'b0000, 1, 1, 16'h000C, 0, 1);
        vecs[13] = mk(4'b0100, 16'h1000, 16'h2000, 4'hF, 4'hF, 1, 0, 4'b0100, 1, 2, 16'h3001, 0, 1);
        vecs[14] = mk(4'b0000, 16'h0000, 16'h0000, 4'h0, 4'hF, 1, 0, 4'b0000, 0, 0, 16'h0000, 0, 0);
        // clear after first word of a req1 chain; restart uses req_cin_i
        vecs[15] = mk(4'b0010, 16'hFFFF, 16'hFFFF, 4'hF, 4'h0, 1, 0, 4'b0010, 1, 1, 16'hFFFF, 1, 0);
        vecs[16] = mk(4'b0010, 16'hFFFF, 16'hFFFF, 4'hF, 4'h0, 1, 1, 4'b0000, 0, 0, 16'h0000, 0, 0);
        vecs[17] = mk(4'b0010, 16'h0001, 16'h0001, 4'h0, 4'hF, 1, 0, 4'b0010, 1, 1, 16'h0002, 0, 1);

        // ---------------- reset state ----------------
        drive(4'hF, '0, '0, 4'h0, 4'hF, 1'b1, 1'b0);
        #2;
        check("rst_ready", bus.req_ready_o, 4'b0000);
        check("rst_valid", bus.resp_valid_o, 1'b0);
        check("rst_id", bus.resp_id_o, 2'd0);
        check("rst_sum", bus.resp_sum_o, 16'h0);
        check("rst_cout", bus.resp_cout_o, 1'b0);
        check("rst_last", bus.resp_last_o, 1'b0);
        drive(4'h0, '0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].valid, {4{vecs[i].a}}, {4{vecs[i].b}}, vecs[i].cin, vecs[i].last,
                  vecs[i].rr, vecs[i].clr);
            #3;
            check($sformatf("vec%0d_ready", i), bus.req_ready_o, vecs[i].exp_ready);
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_rvalid", i), bus.resp_valid_o, vecs[i].exp_rv);
            if (vecs[i].exp_rv) begin
                check($sformatf("vec%0d_id", i), bus.resp_id_o, vecs[i].exp_id);
                check($sformatf("vec%0d_sum", i), bus.resp_sum_o, vecs[i].exp_sum);
                check($sformatf("vec%0d_cout", i), bus.resp_cout_o, vecs[i].exp_cout);
                check($sformatf("vec%0d_last", i), bus.resp_last_o, vecs[i].exp_last);
            end
            $display("vec %0d: valid=%b ready=%b resp_valid=%b id=%0d sum=%h cout=%b last=%b",
                     i, vecs[i].valid, bus.req_ready_o, bus.resp_valid_o, bus.resp_id_o,
                     bus.resp_sum_o, bus.resp_cout_o, bus.resp_last_o);
        end

        // ---------------- async reset mid-chain with response pending ----------------
        drive(4'b0100, {4{16'h1111}}, {4{16'h1111}}, 4'h0, 4'h0, 1'b1, 1'b0);
        #3;
        check("arst_first_ready", bus.req_ready_o, 4'b0100);
        @(posedge clk_i);
        #1;
        check("arst_first_sum", bus.resp_sum_o, 16'h2222);
        check("arst_first_last", bus.resp_last_o, 1'b0);
        drive(4'hF, {4{16'h0002}}, {4{16'h0003}}, 4'h0, 4'hF, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", bus.resp_valid_o, 1'b0);
        check("arst_sum", bus.resp_sum_o, 16'h0);
        check("arst_id", bus.resp_id_o, 2'd0);
        check("arst_ready", bus.req_ready_o, 4'b0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("arst_resume_ready", bus.req_ready_o, 4'b0001);
        @(posedge clk_i);
        #1;
        check("arst_resume_valid", bus.resp_valid_o, 1'b1);
        check("arst_resume_id", bus.resp_id_o, 2'd0);
        check("arst_resume_sum", bus.resp_sum_o, 16'h0005);
        $display("async reset: resumed with id=%0d sum=%h", bus.resp_id_o, bus.resp_sum_o);

        // ---------------- randomized run against the model ----------------
        drive(4'h0, '0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        rst_ni = 1'b0;
        #2;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        model_reset();

        for (int c = 0; c < 400; c++) begin
            rv4 = 4'($urandom_range(0, 15));
            rc4 = 4'($urandom_range(0, 15));
            rl4 = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = {4{16'hFFFF}};
            if ($urandom_range(0, 7) == 0) rb = '0;
            rrr = ($urandom_range(0, 3) != 0);
            rcl = ($urandom_range(0, 31) == 0);
            er  = model_ready(rv4, rrr, rcl);
            drive(rv4, ra, rb, rc4, rl4, rrr, rcl);
            #3;
            check($sformatf("rnd%0d_ready", c), bus.req_ready_o, er);
            model_update(rv4, ra, rb, rc4, rl4, rrr, rcl, er);
            @(posedge clk_i);
            #1;
            check($sformatf("rnd%0d_rvalid", c), bus.resp_valid_o, m_rv);
            if (m_rv) begin
                check($sformatf("rnd%0d_id", c), bus.resp_id_o, m_id[1:0]);
                check($sformatf("rnd%0d_sum", c), bus.resp_sum_o, m_sum);
                check($sformatf("rnd%0d_cout", c), bus.resp_cout_o, m_cout);
                check($sformatf("rnd%0d_last", c), bus.resp_last_o, m_last);
            end
            if ((rv4 & er) != '0 && !rcl) begin
                $display("rnd %0d: accept id=%0d sum=%h cout=%b last=%b", c, m_id, m_sum,
                         m_cout, m_last);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
